spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI master driving the existing SPI slave/RAM wrapper from the other end of the MOSI/MISO/SS_n link. Single clock domain.
- Host side issues 10-bit commands over a valid/ready handshake; the block serialises them onto MOSI.
- For read-data commands (cmd[9:8]=11) it collects 8 bits from MISO and returns them on a response port.
- Used as the active stimulus/master in system-level SPI benches and as synthesisable host logic.

Parameters:
- RD_LATENCY, 2, cycles SS_n stays low with MOSI=0 between the last command bit and the first MISO sample (legal 1..15).
- CMD_W, 10, command word width (fixed by protocol; taken from package).
- DATA_W, 8, read data width (fixed by protocol; taken from package).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_data  in  10  command: [9:8] opcode, [7:0] address/data.
- cmd_ready  out  1  high only in IDLE; a command transfers when cmd_valid && cmd_ready.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  read byte, held until the next read completes.
- busy  out  1  state != IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial out, registered.
- MISO  in  1  serial in, sampled on posedge.

Behaviour:
- Reset, synchronous, active-high. Next edge forces state=IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, counters=0.
- cmd_ready is 0 while rst=1 and 1 in IDLE after release.
- Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- States:
  - IDLE: SS_n=1, MOSI=0. On handshake, latch cmd_data and go to SEL.
  - SEL (1 cycle): SS_n=0, MOSI=cmd[9] (read/write select bit). Go to SHIFT.
  - SHIFT (10 cycles): SS_n=0, MOSI=cmd[9] down to cmd[0], MSB first, one bit per cycle; 4-bit counter.
    - After bit 0: opcode 11 goes to WAIT; all other opcodes go to END.
  - WAIT (RD_LATENCY cycles): SS_n=0, MOSI=0. Go to READ.
  - READ (8 cycles): SS_n=0, MOSI=0. Shift MISO into rx_shreg MSB first on each posedge. Go to END.
  - END (1 cycle): SS_n=1, MOSI=0.
    - If the frame was RD_DATA: rsp_data=rx_shreg and rsp_valid=1 in this cycle.
    - Then IDLE.
- Frame lengths (SS_n low):
  - Write and RD_ADDR: 11 cycles.
  - RD_DATA: 11+RD_LATENCY+8 cycles (21 at default).
- Back-to-back: with cmd_valid held high, SS_n is high for exactly 2 cycles between frames (END + IDLE accept cycle).
- cmd_data changes while busy are ignored; the latched copy is used.
- Reset mid-frame: frame aborts; SS_n=1 on the next edge; no rsp_valid; rsp_data cleared.
- cmd_valid asserted in the same cycle as rst=1: not accepted.
- MISO is ignored outside READ.

Optional Feature:
- SPI_MASTER_SVA_EN defined: embedded assertions plus matching cover properties:
  - (a) rst |=> SS_n && !MOSI && !rsp_valid.
  - (b) SS_n |-> !busy || state==END.
  - (c) rsp_valid |-> SS_n.
  - (d) each low period of SS_n is 11 or 11+RD_LATENCY+8 cycles.
- Undefined: no assertion code compiled; functional behaviour identical.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, SEL, SHIFT, WAIT, READ, END};
  - opcode constants WR_ADDR, WR_DATA, RD_ADDR, RD_DATA;
  - CMD_W=10, DATA_W=8.
  - Shared with the slave bench.
- One sub-module, spi_shift_reg: parallel-load / serial-shift register with bit counter, instantiated twice (TX 10-bit load/shift-out, RX 8-bit shift-in).

Test Plan:
- Reset: assert rst 3 cycles mid-SHIFT -> SS_n=1, MOSI=0, rsp_valid=0 on the next edge; cmd_ready=1 the cycle after release.
- Write address: cmd_data=10'h0A5 (00_1010_0101) -> SS_n low 11 cycles; MOSI sequence 0,0,0,1,0,1,0,0,1,0,1; no rsp_valid.
- Read data: cmd_data=10'h300, slave model drives 0xC3 MSB first from cycle 13 after SS_n falls -> SS_n low 21 cycles; rsp_valid pulse coincides with SS_n rising; rsp_data=8'hC3.
- Back-to-back: WR_ADDR 0x012, WR_DATA 0x1AB, RD_ADDR 0x212, RD_DATA 0x300 with cmd_valid held -> SS_n high exactly 2 cycles between frames; RD_DATA returns the byte written (0xAB) when connected to the wrapper.
- Parameter sweep: RD_LATENCY=1 and 4 -> RD_DATA frame length 20 and 23 cycles; data is captured correctly in both cases.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM states, opcodes and protocol widths.
// Used by the master RTL and by the slave-side benches.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    WAIT,
    READ,
    END
  } spi_state_e;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial-shift register (MSB first) with a shift counter;
// last is high on the W-th shift cycle after a load.
module spi_shift_reg #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         ser_in,
  output logic [W-1:0] q,
  output logic         last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= '0;
    end else if (shift) begin
      q   <= {q[W-2:0], ser_in};
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(W-1));

endmodule

// File: rtl/spi_master.sv
// SPI master: 10-bit command frames out on MOSI, 8-bit read-back on MISO.
// Define SPI_MASTER_SVA_EN to compile the embedded assertions and covers.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // TX holds {cmd[9], cmd}: the select bit is repeated ahead of the word, and
  // zero fill makes MOSI fall back to 0 once the word has been shifted out.
  localparam int TX_W = CMD_W + 1;

  spi_state_e        state, state_nxt;
  logic              accept, rd_done, wait_last, tx_last, rx_last;
  logic [1:0]        op_q;
  logic [3:0]        wait_cnt;
  logic [TX_W-1:0]   tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              unused_bits;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign MOSI      = tx_q[TX_W-1];
  assign wait_last = (wait_cnt == 4'(RD_LATENCY-1));
  assign rd_done   = (state == READ) && rx_last;
  assign unused_bits = ^{tx_q[TX_W-2:0], rx_q[DATA_W-1]};

  spi_shift_reg #(.W(TX_W), .CNT_W(4)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ({cmd_data[CMD_W-1], cmd_data}),
    .shift    ((state == SEL) || (state == SHIFT)),
    .ser_in   (1'b0),
    .q        (tx_q),
    .last     (tx_last)
  );

  spi_shift_reg #(.W(DATA_W), .CNT_W(4)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .shift    (state == READ),
    .ser_in   (MISO),
    .q        (rx_q),
    .last     (rx_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEL;
      SEL:     state_nxt = SHIFT;
      SHIFT:   if (tx_last) state_nxt = (op_q == RD_DATA) ? WAIT : END;
      WAIT:    if (wait_last) state_nxt = READ;
      READ:    if (rx_last) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SS_n is registered from the next state so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      wait_cnt  <= '0;
      SS_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) op_q <= cmd_data[CMD_W-1 -: 2];
      wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : 4'd0;
      SS_n      <= (state_nxt == IDLE) || (state_nxt == END);
      rsp_valid <= rd_done;
      if (rd_done) rsp_data <= {rx_q[DATA_W-2:0], MISO};
    end
  end

`ifdef SPI_MASTER_SVA_EN
  logic [5:0] sva_low_len;

  always_ff @(posedge clk) begin
    if (rst || SS_n) sva_low_len <= '0;
    else             sva_low_len <= sva_low_len + 1'b1;
  end

  a_rst_idle: assert property (@(posedge clk) rst |=> SS_n && !MOSI && !rsp_valid);
  a_ss_busy:  assert property (@(posedge clk) disable iff (rst) SS_n |-> !busy || state == END);
  a_rsp_ss:   assert property (@(posedge clk) disable iff (rst) rsp_valid |-> SS_n);
  a_frame_len: assert property (@(posedge clk) disable iff (rst)
    (SS_n && sva_low_len != '0) |-> (sva_low_len == 6'd11) || (sva_low_len == 6'(19 + RD_LATENCY)));

  c_rst_idle:  cover property (@(posedge clk) rst ##1 SS_n);
  c_ss_busy:   cover property (@(posedge clk) disable iff (rst) SS_n && state == END);
  c_rsp_ss:    cover property (@(posedge clk) disable iff (rst) rsp_valid && SS_n);
  c_frame_len: cover property (@(posedge clk) disable iff (rst) SS_n && sva_low_len == 6'(19 + RD_LATENCY));
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: three instances (RD_LATENCY 2, 1, 4)
// driven by a cycle-level host/slave model with a RAM-like slave behind MISO.
module tb_spi_master;
  import spi_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NI-1:0] cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
  logic [NI-1:0][CMD_W-1:0]  cmd_data;
  logic [NI-1:0][DATA_W-1:0] rsp_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master #(.RD_LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid[g]),
      .cmd_data  (cmd_data[g]),
      .cmd_ready (cmd_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g]),
      .SS_n      (ss_n[g]),
      .MOSI      (mosi[g]),
      .MISO      (miso[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  logic [CMD_W-1:0]  cmd_q[$];
  int                obs_len[$];
  int                obs_gap[$];
  logic [CMD_W:0]    obs_bits[$];
  logic [DATA_W-1:0] obs_rsp[$];
  int                rsp_bad, mosi_bad;
  bit                timed_out;

  logic [7:0] slv_mem [256];
  logic [7:0] slv_waddr, slv_raddr;

  task automatic slave_clear();
    foreach (slv_mem[a]) slv_mem[a] = 8'h00;
    slv_waddr = 8'h00;
    slv_raddr = 8'h00;
  endtask

  // Host + slave model: issues cmd_q on instance idx, records every SS_n-low
  // frame (length, MOSI bits), gaps between frames and returned bytes.
  task automatic run_frames(input int idx, input bit hold);
    int ci, done, k, gap, idle_after, lat;
    bit in_frame, acc, started, just_ended;
    logic [CMD_W:0] bits;
    logic [1:0] last_op;
    ci = 0; done = 0; k = 0; gap = 0; idle_after = 0; lat = lat_of(idx);
    in_frame = 0; acc = 0; started = 0; bits = '0; last_op = 2'b00;
    obs_len.delete(); obs_gap.delete(); obs_bits.delete(); obs_rsp.delete();
    rsp_bad = 0; mosi_bad = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 4000 && timed_out; cyc++) begin
      @(posedge clk); #1;
      just_ended = 0;
      if (acc) begin ci++; acc = 0; end
      if (ss_n[idx] === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1; k = 0; bits = '0;
          if (started) obs_gap.push_back(gap);
          started = 1;
        end
        if (k < 11) bits[10-k] = mosi[idx];
        else if (mosi[idx] !== 1'b0) mosi_bad++;
        if (bits[9:8] == 2'b11 && k >= 11 + lat && k < 19 + lat)
          miso[idx] = slv_mem[slv_raddr][18 + lat - k];
        else
          miso[idx] = 1'($urandom);
        k++;
      end else begin
        if (mosi[idx] !== 1'b0) mosi_bad++;
        miso[idx] = 1'($urandom);
        if (in_frame) begin
          in_frame = 0; just_ended = 1; last_op = bits[9:8];
          obs_len.push_back(k); obs_bits.push_back(bits);
          case (bits[9:8])
            2'b00:   slv_waddr = bits[7:0];
            2'b01:   slv_mem[slv_waddr] = bits[7:0];
            2'b10:   slv_raddr = bits[7:0];
            default: ;
          endcase
          done++; gap = 0;
        end
        gap++;
      end
      if (rsp_valid[idx] === 1'b1) begin
        obs_rsp.push_back(rsp_data[idx]);
        if (!(just_ended && last_op == 2'b11)) rsp_bad++;
      end else if (just_ended && last_op == 2'b11) rsp_bad++;
      if (ci < cmd_q.size() && (hold || $urandom_range(0, 2) == 0)) begin
        cmd_valid[idx] = 1'b1;
        cmd_data[idx]  = cmd_q[ci];
        acc = (cmd_ready[idx] === 1'b1);
      end else begin
        cmd_valid[idx] = 1'b0;
        cmd_data[idx]  = 10'($urandom);
      end
      if (done == cmd_q.size() && !in_frame) idle_after++;
      if (idle_after >= 3) timed_out = 1'b0;
    end
    cmd_valid[idx] = 1'b0;
    miso[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ss_n[i], mosi[i], rsp_valid[i], busy[i], cmd_ready[i], rsp_data[i]} !== {5'b10000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got ss_n/mosi/rsp_valid/busy/ready=%b%b%b%b%b rsp_data=%h, want 10000 00",
                 i, ss_n[i], mosi[i], rsp_valid[i], busy[i], cmd_ready[i], rsp_data[i]);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 111", cmd_ready);
    end
  endtask

  task automatic test_write_addr();
    logic [CMD_W-1:0] c;
    c = 10'h0A5;
    slave_clear(); cmd_q.delete(); cmd_q.push_back(c);
    run_frames(0, 1'b0);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: frame never completed"); end
    n_checks++;
    if (obs_len.size() != 1 || obs_len[0] != 11) begin
      n_fail++; $display("FAIL wr_len: got %0d frames len %0d want 1 frame len 11",
                         obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1);
    end
    n_checks++;
    if (obs_bits.size() != 1 || obs_bits[0] !== 11'b000_1010_0101) begin
      n_fail++; $display("FAIL wr_mosi: got %b want 00010100101", (obs_bits.size() > 0) ? obs_bits[0] : 11'h0);
    end
    n_checks++;
    if (obs_rsp.size() != 0 || rsp_bad != 0 || mosi_bad != 0) begin
      n_fail++; $display("FAIL wr_side: rsp=%0d rsp_bad=%0d mosi_bad=%0d want 0/0/0", obs_rsp.size(), rsp_bad, mosi_bad);
    end
  endtask

  task automatic test_read_data();
    slave_clear(); slv_mem[0] = 8'hC3;
    cmd_q.delete(); cmd_q.push_back(10'h300);
    run_frames(0, 1'b0);
    n_checks++;
    if (timed_out !== 1'b0 || obs_len.size() != 1 || obs_len[0] != 21) begin
      n_fail++; $display("FAIL rd_len: timeout=%b frames=%0d len=%0d want 21", timed_out,
                         obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1);
    end
    n_checks++;
    if (obs_rsp.size() != 1 || obs_rsp[0] !== 8'hC3 || rsp_bad != 0) begin
      n_fail++; $display("FAIL rd_rsp: got %0d rsp first=%h bad=%0d want one C3 at SS_n rise",
                         obs_rsp.size(), (obs_rsp.size() > 0) ? obs_rsp[0] : 8'h00, rsp_bad);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_data[0] !== 8'hC3 || rsp_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL rd_hold: rsp_data=%h rsp_valid=%b want C3/0", rsp_data[0], rsp_valid[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen_low;
    int rv_cnt, low_cnt;
    seen_low = 0; rv_cnt = 0; low_cnt = 0;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1; cmd_data[0] = 10'h3A5;
    for (int t = 0; t < 10 && !seen_low; t++) begin
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      if (ss_n[0] === 1'b0) seen_low = 1;
    end
    n_checks++;
    if (!seen_low) begin n_fail++; $display("FAIL mid_start: SS_n never fell"); end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; cmd_valid[0] = 1'b1; cmd_data[0] = 10'h000;
    @(posedge clk); #1;
    n_checks++;
    if ({ss_n[0], mosi[0], rsp_valid[0], busy[0], cmd_ready[0], rsp_data[0]} !== {5'b10000, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset: got ss_n/mosi/rsp_valid/busy/ready=%b%b%b%b%b rsp_data=%h want 10000 00",
                         ss_n[0], mosi[0], rsp_valid[0], busy[0], cmd_ready[0], rsp_data[0]);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (ss_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_fail++; $display("FAIL mid_rst_accept: ss_n=%b busy=%b want 1/0 while rst", ss_n[0], busy[0]);
      end
    end
    rst = 1'b0; cmd_valid[0] = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", cmd_ready[0]); end
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid[0] === 1'b1) rv_cnt++;
      if (ss_n[0] !== 1'b1) low_cnt++;
    end
    n_checks++;
    if (rv_cnt != 0 || low_cnt != 0) begin
      n_fail++; $display("FAIL mid_abort: rsp_valid=%0d ss_low=%0d want 0/0", rv_cnt, low_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int exp_len[4] = '{11, 11, 11, 21};
    slave_clear(); cmd_q.delete();
    cmd_q.push_back(10'h012); cmd_q.push_back(10'h1AB); cmd_q.push_back(10'h212); cmd_q.push_back(10'h300);
    run_frames(0, 1'b1);
    n_checks++;
    if (timed_out !== 1'b0 || obs_len.size() != 4 || obs_gap.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: timeout=%b frames=%0d gaps=%0d want 0/4/3", timed_out, obs_len.size(), obs_gap.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        n_checks++;
        if (obs_len[f] != exp_len[f] || obs_bits[f] !== {cmd_q[f][9], cmd_q[f]}) begin
          n_fail++; $display("FAIL b2b_frame%0d: len %0d bits %b want len %0d bits %b",
                             f, obs_len[f], obs_bits[f], exp_len[f], {cmd_q[f][9], cmd_q[f]});
        end
      end
      for (int f = 0; f < 3; f++) begin
        n_checks++;
        if (obs_gap[f] != 2) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 2", f, obs_gap[f]); end
      end
    end
    n_checks++;
    if (obs_rsp.size() != 1 || obs_rsp[0] !== 8'hAB || rsp_bad != 0 || mosi_bad != 0) begin
      n_fail++; $display("FAIL b2b_rsp: n=%0d first=%h rsp_bad=%0d mosi_bad=%0d want one AB",
                         obs_rsp.size(), (obs_rsp.size() > 0) ? obs_rsp[0] : 8'h00, rsp_bad, mosi_bad);
    end
  endtask

  task automatic test_latency_sweep();
    logic [7:0] d, a;
    int exp_rd;
    for (int idx = 1; idx < NI; idx++) begin
      d = 8'($urandom); a = 8'($urandom);
      exp_rd = (idx == 1) ? 20 : 23;
      slave_clear(); cmd_q.delete();
      cmd_q.push_back({2'b00, a}); cmd_q.push_back({2'b01, d});
      cmd_q.push_back({2'b10, a}); cmd_q.push_back({2'b11, 8'h5A});
      run_frames(idx, 1'b0);
      n_checks++;
      if (timed_out !== 1'b0 || obs_len.size() != 4 || obs_len[3] != exp_rd) begin
        n_fail++; $display("FAIL lat_len[%0d]: timeout=%b frames=%0d rd_len=%0d want %0d", idx, timed_out,
                           obs_len.size(), (obs_len.size() == 4) ? obs_len[3] : -1, exp_rd);
      end
      n_checks++;
      if (obs_rsp.size() != 1 || obs_rsp[0] !== d || rsp_bad != 0) begin
        n_fail++; $display("FAIL lat_rsp[%0d]: got %h (n=%0d bad=%0d) want %h", idx,
                           (obs_rsp.size() > 0) ? obs_rsp[0] : 8'h00, obs_rsp.size(), rsp_bad, d);
      end
    end
  endtask

  task automatic test_random();
    int idx, nerr;
    logic [7:0] ref_mem [256];
    logic [7:0] wa, ra;
    int exp_len[$];
    logic [7:0] exp_rsp[$];
    logic [CMD_W-1:0] c;
    idx = $urandom_range(0, NI-1);
    foreach (ref_mem[a]) ref_mem[a] = 8'h00;
    wa = 8'h00; ra = 8'h00; nerr = 0;
    slave_clear(); cmd_q.delete();
    for (int n = 0; n < 24; n++) begin
      c = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      cmd_q.push_back(c);
      case (c[9:8])
        2'b00: begin wa = c[7:0]; exp_len.push_back(11); end
        2'b01: begin ref_mem[wa] = c[7:0]; exp_len.push_back(11); end
        2'b10: begin ra = c[7:0]; exp_len.push_back(11); end
        default: begin exp_rsp.push_back(ref_mem[ra]); exp_len.push_back(19 + lat_of(idx)); end
      endcase
    end
    run_frames(idx, 1'b0);
    n_checks++;
    if (timed_out !== 1'b0 || obs_len.size() != 24 || obs_rsp.size() != exp_rsp.size()) begin
      n_fail++; $display("FAIL rnd_count[%0d]: timeout=%b frames=%0d rsp=%0d want 24/%0d",
                         idx, timed_out, obs_len.size(), obs_rsp.size(), exp_rsp.size());
    end else begin
      for (int f = 0; f < 24; f++) begin
        n_checks++;
        if (obs_len[f] != exp_len[f] || obs_bits[f] !== {cmd_q[f][9], cmd_q[f]}) begin
          n_fail++; nerr++;
          if (nerr < 6) $display("FAIL rnd_frame%0d: len %0d bits %b want len %0d bits %b",
                                 f, obs_len[f], obs_bits[f], exp_len[f], {cmd_q[f][9], cmd_q[f]});
        end
      end
      foreach (exp_rsp[r]) begin
        n_checks++;
        if (obs_rsp[r] !== exp_rsp[r]) begin
          n_fail++; $display("FAIL rnd_rsp%0d: got %h want %h", r, obs_rsp[r], exp_rsp[r]);
        end
      end
    end
    n_checks++;
    if (rsp_bad != 0 || mosi_bad != 0) begin
      n_fail++; $display("FAIL rnd_side: rsp_bad=%0d mosi_bad=%0d want 0/0", rsp_bad, mosi_bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = '0;
    cmd_data = '0;
    miso = '0;
    test_reset();
    test_write_addr();
    test_read_data();
    test_reset_mid_frame();
    test_back_to_back();
    test_latency_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
